mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control sequencer for the 32-bit processor datapath. It walks each instruction through fetch, decode, execute, memory and writeback states and drives every datapath enable and mux select. It produces the 3-bit ALU operation select and consumes the ALU `zero` flag for branch resolution. Memory accesses use a req/ready handshake so variable-latency memory stalls the sequence.

## Interface
- `ADDR_W`, 32: width of datapath addresses. Informational only; no port uses it.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]. Stable from the cycle after `ir_write` until the next fetch.
- `funct` in 6: IR[5:0]. Stable on the same terms as `opcode`.
- `zero` in 1: ALU zero flag. Valid when `alu_sel`=110.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: qualifies `mem_req` as a write.
- `i_or_d` out 1: memory address source. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR.
- `pc_en` out 1: PC load enable.
- `pc_src` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a` out 1: ALU operand A. 0 = PC, 1 = register A.
- `alu_src_b` out 2: ALU operand B. 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `alu_sel` out 3: ALU operation. 000 and, 001 or, 010 add, 100 andnot, 101 ornot, 110 sub, 111 slt.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: destination register. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback source. 0 = ALUOut, 1 = MDR.
- `instr_done` out 1: one-cycle pulse on the final cycle of each instruction.
- `illegal` out 1: sticky flag for an unsupported opcode or funct.

## Operation
- Moore machine. All outputs decode combinationally from the state register, with two exceptions:
  - `pc_en` in BEQ, which also depends on `zero`.
  - Handshake-qualified strobes, which also depend on `mem_ready`.
- Outputs not listed for a state are 0. `alu_sel` defaults to 010.
- State encoding is 4 bits. States and transitions:
  - RESET: all outputs 0. Next state FETCH.
  - FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_sel`=010, `pc_src`=00. `ir_write` and `pc_en` are 1 only when `mem_ready`=1. Stay in FETCH while `mem_ready`=0; go to DECODE on `mem_ready`=1.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_sel`=010 (branch target). Next state by opcode:
    - 100011 (lw) or 101011 (sw): MEMADR.
    - 000000: RTYPE.
    - 000100: BEQ.
    - 001000 (addi): ADDI.
    - 000010: JUMP.
    - Any other opcode: TRAP.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_sel`=010. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD: `mem_req`=1, `i_or_d`=1. Stay while not ready; go to MEMWB on ready.
  - MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1. Next state FETCH.
  - MEMWR: `mem_req`=1, `mem_write`=1, `i_or_d`=1. Stay while not ready. On ready, `instr_done`=1 and next state FETCH.
  - RTYPE: `alu_src_a`=1, `alu_src_b`=00. `alu_sel` from `funct`:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - Any other funct: next state TRAP, with no register write.
    - Otherwise next state RTYPE_WB.
  - RTYPE_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1. Next state FETCH.
  - BEQ: `alu_src_a`=1, `alu_src_b`=00, `alu_sel`=110, `pc_src`=01, `pc_en`=`zero`, `instr_done`=1. Next state FETCH.
  - ADDI: `alu_src_a`=1, `alu_src_b`=10, `alu_sel`=010. Next state ADDI_WB.
  - ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0, `instr_done`=1. Next state FETCH.
  - JUMP: `pc_src`=10, `pc_en`=1, `instr_done`=1. Next state FETCH.
  - TRAP: `illegal`=1, all other outputs 0. Remains in TRAP until reset.
- Unused state encodings go to RESET on the next clock.

## Timing
- Reset:
  - Asserting `rst_n` low forces RESET immediately, including in the middle of any state or mid-handshake.
  - During reset, `mem_req` and all write enables drop to 0 combinationally.
  - `illegal` clears.
- First FETCH occurs on the second rising edge after `rst_n` deasserts.
- Instruction latency with zero-wait memory (`mem_ready` held 1), counting from FETCH through the `instr_done` cycle:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait cycle on an access adds exactly one cycle to FETCH, MEMRD or MEMWR.
- Handshake:
  - `mem_req`, `mem_write` and `i_or_d` hold constant for every cycle of a stalled access.
  - The access completes in the first cycle with `mem_req`=1 and `mem_ready`=1.
  - `mem_ready` is ignored in every other state.
- At most one of `reg_write`, `mem_write`, `ir_write` is high in any cycle.
- `instr_done` is never high in two consecutive cycles.

## Test plan
- Reset then addi, `mem_ready`=1: state sequence RESET, FETCH, DECODE, ADDI, ADDI_WB. In ADDI_WB, `reg_write`=1 and `reg_dst`=0. `instr_done` pulses at cycle 4 after FETCH entry.
- lw with `mem_ready` low for 2 cycles in FETCH and 3 cycles in MEMRD: 10 cycles total from first FETCH to `instr_done`. `mem_req` is steady throughout each stall. `ir_write` and `pc_en` pulse exactly once.
- R-type with each funct in {100000, 100010, 100100, 100101, 101010}: `alu_sel` is respectively 010, 110, 000, 001, 111 in RTYPE. `reg_dst`=1 in RTYPE_WB.
- beq with `zero`=1, then beq with `zero`=0: `pc_en`=1 with `pc_src`=01 in the first BEQ cycle; `pc_en`=0 in the second. Both are 3 cycles.
- Opcode 111111, and R-type with funct 000000: both go to TRAP. `illegal`=1 sticks, no `reg_write` or `mem_req` occurs. Asserting `rst_n`=0 clears `illegal`.
- Assert `rst_n` low mid-MEMWR while `mem_ready`=0: `mem_write` drops to 0 the same cycle. After release, execution restarts at RESET then FETCH.

Source files
------------

// File: rtl/mc_if.sv
// Control bus between the multi-cycle sequencer and the datapath/memory.
// The sequencer is the master: it consumes IR fields and status, drives every enable and select.
interface mc_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_write;
  logic       i_or_d;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_sel;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src,
           alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
           mem_to_reg, instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, mem_write, i_or_d, ir_write, pc_en, pc_src,
           alu_src_a, alu_src_b, alu_sel, reg_write, reg_dst,
           mem_to_reg, instr_done, illegal
  );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback FSM
// driving the datapath enables and selects, with req/ready memory stalls.
module mc_control (
  input logic   clk,
  input logic   rst_n,
  mc_if.master  bus
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTYPE, S_RTYPE_WB, S_BEQ, S_ADDI, S_ADDI_WB, S_JUMP, S_TRAP
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state, state_nx;
  logic   started;

  // started holds RESET for one extra edge after release, so the first
  // FETCH lands on the second rising edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; asynchronous reset appears in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RESET;
      started <= 1'b0;
    end else begin
      state   <= state_nx;
      started <= 1'b1;
    end
  end

  // NOTE: every output and state_nx gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_nx       = state;
    bus.mem_req    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_en      = 1'b0;
    bus.pc_src     = 2'b00;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_sel    = ALU_ADD;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.instr_done = 1'b0;
    bus.illegal    = 1'b0;

    case (state)
      S_RESET: begin
        bus.alu_sel = 3'b000;
        state_nx    = started ? S_FETCH : S_RESET;
      end
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_en     = bus.mem_ready;
        if (bus.mem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYP:      state_nx = S_RTYPE;
          OP_BEQ:       state_nx = S_BEQ;
          OP_ADDI:      state_nx = S_ADDI;
          OP_J:         state_nx = S_JUMP;
          default:      state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_nx      = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.i_or_d  = 1'b1;
        if (bus.mem_ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.instr_done = 1'b1;
        state_nx       = S_FETCH;
      end
      S_MEMWR: begin
        bus.mem_req    = 1'b1;
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
        if (bus.mem_ready) state_nx = S_FETCH;
      end
      S_RTYPE: begin
        bus.alu_src_a = 1'b1;
        state_nx      = S_RTYPE_WB;
        case (bus.funct)
          6'b100000: bus.alu_sel = ALU_ADD;
          6'b100010: bus.alu_sel = ALU_SUB;
          6'b100100: bus.alu_sel = ALU_AND;
          6'b100101: bus.alu_sel = ALU_OR;
          6'b101010: bus.alu_sel = ALU_SLT;
          default:   state_nx    = S_TRAP;
        endcase
      end
      S_RTYPE_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 1'b1;
        bus.instr_done = 1'b1;
        state_nx       = S_FETCH;
      end
      S_BEQ: begin
        bus.alu_src_a  = 1'b1;
        bus.alu_sel    = ALU_SUB;
        bus.pc_src     = 2'b01;
        bus.pc_en      = bus.zero;
        bus.instr_done = 1'b1;
        state_nx       = S_FETCH;
      end
      S_ADDI: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_nx      = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_nx       = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_src     = 2'b10;
        bus.pc_en      = 1'b1;
        bus.instr_done = 1'b1;
        state_nx       = S_FETCH;
      end
      S_TRAP: begin
        bus.alu_sel = 3'b000;
        bus.illegal = 1'b1;
      end
      default: state_nx = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-cycle vector table of inputs and expected
// outputs, plus hand sequences for async reset mid-write and stalled lw latency.
module tb_mc_control;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mc_if bus ();

  mc_control dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;
  } outs_t;

  //                                 req   wr    iod   irw   pce   pcs    asa   asb    alu     rw    rd    m2r   done  ill
  localparam outs_t O_RESET   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_FETCH_W = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_FETCH_R = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_DECODE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_MEMADR  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_MEMRD   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_MEMWB   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam outs_t O_MEMWR_W = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_MEMWR_R = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam outs_t O_RTYPE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_RTWB    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam outs_t O_BEQ_T   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 2'b00, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam outs_t O_BEQ_N   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam outs_t O_ADDI    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_ADDIWB  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam outs_t O_JUMP    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam outs_t O_TRAP    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  typedef struct {
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    outs_t      exp;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, got, exp);
  endtask

  function automatic outs_t sample();
    outs_t o;
    o.mem_req    = bus.mem_req;    o.mem_write  = bus.mem_write;
    o.i_or_d     = bus.i_or_d;     o.ir_write   = bus.ir_write;
    o.pc_en      = bus.pc_en;      o.pc_src     = bus.pc_src;
    o.alu_src_a  = bus.alu_src_a;  o.alu_src_b  = bus.alu_src_b;
    o.alu_sel    = bus.alu_sel;    o.reg_write  = bus.reg_write;
    o.reg_dst    = bus.reg_dst;    o.mem_to_reg = bus.mem_to_reg;
    o.instr_done = bus.instr_done; o.illegal    = bus.illegal;
    return o;
  endfunction

  function automatic outs_t rtype(input logic [2:0] sel);
    outs_t o = O_RTYPE;
    o.alu_sel = sel;
    return o;
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rd, input outs_t e);
    vec_t v;
    v.rst = r; v.opcode = op; v.funct = fn; v.zero = z; v.rdy = rd; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(posedge clk);
  endtask

  initial begin : main
    logic [5:0] fn_tab  [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] sel_tab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic prev_done;
    bus.opcode = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    // reset, then RESET is held across the first edge; FETCH after the second
    add(1, ADDI, 0, 0, 1, O_RESET);
    add(0, ADDI, 0, 0, 1, O_RESET);
    add(0, ADDI, 0, 0, 1, O_RESET);
    // addi
    add(0, ADDI, 0, 0, 1, O_FETCH_R); add(0, ADDI, 0, 0, 0, O_DECODE);
    add(0, ADDI, 0, 0, 0, O_ADDI);    add(0, ADDI, 0, 0, 0, O_ADDIWB);
    // lw: two FETCH waits, three MEMRD waits
    add(0, LW, 0, 0, 0, O_FETCH_W); add(0, LW, 0, 0, 0, O_FETCH_W); add(0, LW, 0, 0, 1, O_FETCH_R);
    add(0, LW, 0, 0, 0, O_DECODE);  add(0, LW, 0, 0, 1, O_MEMADR);
    add(0, LW, 0, 0, 0, O_MEMRD);   add(0, LW, 0, 0, 0, O_MEMRD);   add(0, LW, 0, 0, 0, O_MEMRD);
    add(0, LW, 0, 0, 1, O_MEMRD);   add(0, LW, 0, 0, 1, O_MEMWB);
    // sw with one write wait
    add(0, SW, 0, 0, 1, O_FETCH_R); add(0, SW, 0, 0, 1, O_DECODE); add(0, SW, 0, 0, 1, O_MEMADR);
    add(0, SW, 0, 0, 0, O_MEMWR_W); add(0, SW, 0, 0, 1, O_MEMWR_R);
    // R-type, each supported funct
    for (int k = 0; k < 5; k++) begin
      add(0, RT, fn_tab[k], 0, 1, O_FETCH_R); add(0, RT, fn_tab[k], 0, 1, O_DECODE);
      add(0, RT, fn_tab[k], 0, 1, rtype(sel_tab[k])); add(0, RT, fn_tab[k], 0, 1, O_RTWB);
    end
    // beq taken, then not taken
    add(0, BEQ, 0, 1, 1, O_FETCH_R); add(0, BEQ, 0, 1, 1, O_DECODE); add(0, BEQ, 0, 1, 1, O_BEQ_T);
    add(0, BEQ, 0, 0, 1, O_FETCH_R); add(0, BEQ, 0, 0, 1, O_DECODE); add(0, BEQ, 0, 0, 1, O_BEQ_N);
    // jump
    add(0, J, 0, 0, 1, O_FETCH_R); add(0, J, 0, 0, 1, O_DECODE); add(0, J, 0, 0, 1, O_JUMP);
    // unsupported funct traps and sticks
    add(0, RT, 6'b000000, 0, 1, O_FETCH_R); add(0, RT, 6'b000000, 0, 1, O_DECODE);
    add(0, RT, 6'b000000, 0, 1, rtype(3'b010));
    add(0, RT, 6'b000000, 0, 1, O_TRAP); add(0, ADDI, 0, 0, 1, O_TRAP);
    // reset clears illegal; then unsupported opcode traps
    add(1, BAD, 0, 0, 1, O_RESET); add(0, BAD, 0, 0, 1, O_RESET); add(0, BAD, 0, 0, 1, O_RESET);
    add(0, BAD, 0, 0, 1, O_FETCH_R); add(0, BAD, 0, 0, 1, O_DECODE);
    add(0, BAD, 0, 0, 1, O_TRAP); add(0, BAD, 0, 0, 1, O_TRAP);
    // reset during a stalled write, restart RESET, RESET, FETCH
    add(1, SW, 0, 0, 1, O_RESET); add(0, SW, 0, 0, 1, O_RESET); add(0, SW, 0, 0, 1, O_RESET);
    add(0, SW, 0, 0, 1, O_FETCH_R); add(0, SW, 0, 0, 1, O_DECODE); add(0, SW, 0, 0, 1, O_MEMADR);
    add(0, SW, 0, 0, 0, O_MEMWR_W); add(1, SW, 0, 0, 0, O_RESET);
    add(0, SW, 0, 0, 1, O_RESET);   add(0, SW, 0, 0, 1, O_RESET); add(0, SW, 0, 0, 1, O_FETCH_R);

    prev_done = 1'b0;
    foreach (vecs[i]) begin
      outs_t got;
      @(negedge clk);
      rst_n = !vecs[i].rst;
      bus.opcode = vecs[i].opcode; bus.funct = vecs[i].funct;
      bus.zero = vecs[i].zero;     bus.mem_ready = vecs[i].rdy;
      #1;
      got = sample();
      check($sformatf("vec%0d", i), 32'(got), 32'(vecs[i].exp));
      check($sformatf("vec%0d_one_write", i),
            32'(int'(got.reg_write) + int'(got.mem_write) + int'(got.ir_write) <= 1), 32'd1);
      check($sformatf("vec%0d_done_pair", i), 32'(prev_done & got.instr_done), 32'd0);
      prev_done = got.instr_done;
    end

    // async reset between edges while a write is stalled
    begin : mid_reset
      bit reached = 1'b0;
      bus.opcode = SW; bus.mem_ready = 1'b1;
      do_reset();
      for (int c = 0; c < 10 && !reached; c++) begin
        @(negedge clk);
        if (bus.mem_req && bus.mem_write) begin
          bus.mem_ready = 1'b0;
          reached = 1'b1;
        end
      end
      check("memwr_reached", 32'(reached), 32'd1);
      @(posedge clk); #2;
      check("memwr_stalled", 32'(bus.mem_write), 32'd1);
      rst_n = 1'b0; #1;
      check("async_mem_write", 32'(bus.mem_write), 32'd0);
      check("async_mem_req", 32'(bus.mem_req), 32'd0);
      @(negedge clk); rst_n = 1'b1; bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      check("restart_reset", 32'(bus.mem_req), 32'd0);
      @(posedge clk); #1;
      check("restart_fetch", 32'({bus.mem_req, bus.i_or_d}), 32'b10);
    end

    // lw with wait cycles driven from the observed request
    begin : lw_stall
      int  waits = 2, cyc = 0, n_ir = 0, n_pc = 0;
      bit  counting = 1'b0, done_seen = 1'b0, prev_stall = 1'b0;
      logic [2:0] prev_hs = 3'b000;
      bus.opcode = LW; bus.mem_ready = 1'b0;
      do_reset();
      for (int c = 0; c < 40 && !done_seen; c++) begin
        @(negedge clk);
        if (bus.mem_req) begin
          if (waits > 0) begin bus.mem_ready = 1'b0; waits--; end
          else begin bus.mem_ready = 1'b1; waits = 3; end
        end
        #1;
        if (bus.mem_req && !bus.i_or_d) counting = 1'b1;
        if (counting) cyc++;
        n_ir += int'(bus.ir_write);
        n_pc += int'(bus.pc_en);
        if (prev_stall)
          check($sformatf("lw_hold_c%0d", c), 32'({bus.mem_req, bus.mem_write, bus.i_or_d}), 32'(prev_hs));
        prev_stall = bus.mem_req && !bus.mem_ready;
        prev_hs    = {bus.mem_req, bus.mem_write, bus.i_or_d};
        if (bus.instr_done) done_seen = 1'b1;
      end
      check("lw_done_seen", 32'(done_seen), 32'd1);
      check("lw_cycles", 32'(cyc), 32'd10);
      check("lw_ir_write_pulses", 32'(n_ir), 32'd1);
      check("lw_pc_en_pulses", 32'(n_pc), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
